// File: rtl/cvxif_mac4b_result_scheduler.sv
// rtl/cvxif_mac4b_result_scheduler.sv - in-order CV-X-IF result buffer for MAC4B with commit/kill tracking
// Optional perf counters (issued/killed/stall) are enabled by defining CVXIF_MAC4B_SCHED_PERF_EN.
module cvxif_mac4b_result_scheduler #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic              issue_accept_i,
  output logic              issue_ready_o,
  input  logic [ID_W-1:0]   issue_id_i,
  input  logic [4:0]        issue_rd_i,
  input  logic [DATA_W-1:0] issue_data_i,
  input  logic              commit_valid_i,
  input  logic [ID_W-1:0]   commit_id_i,
  input  logic              commit_kill_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ID_W-1:0]   result_id_o,
  output logic [4:0]        result_rd_o,
  output logic [DATA_W-1:0] result_data_o,
  output logic              result_we_o
`ifdef CVXIF_MAC4B_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issued_o,
  output logic [31:0]       perf_killed_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {EMPTY, PENDING, COMMITTED, KILLED} ent_state_e;

  ent_state_e        state_q [DEPTH];
  ent_state_e        state_d [DEPTH];
  logic [ID_W-1:0]   id_q    [DEPTH];
  logic [4:0]        rd_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       push, pop;
  logic       head_committed, head_killed;
  logic       dup_live;
  ent_state_e push_state;

  // Ready depends on the registered count only, so a same-cycle pop never frees a slot.
  assign issue_ready_o  = (count_q < CNT_W'(DEPTH));
  assign push           = issue_valid_i & issue_accept_i & issue_ready_o;
  assign head_committed = (state_q[rd_ptr_q] == COMMITTED);
  assign head_killed    = (state_q[rd_ptr_q] == KILLED);
  assign pop            = (head_committed & result_ready_i) | head_killed;

  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    push_state = PENDING;
    if (commit_valid_i && (issue_id_i == commit_id_i)) begin
      push_state = commit_kill_i ? KILLED : COMMITTED;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && (state_q[i] == PENDING) && (id_q[i] == commit_id_i)) begin
        state_d[i] = commit_kill_i ? KILLED : COMMITTED;
      end
    end
    if (pop) begin
      state_d[rd_ptr_q] = EMPTY;
    end
    if (push) begin
      state_d[wr_ptr_q] = push_state;
    end
  end

  // An entry leaving this cycle no longer counts as live for id reuse.
  always_comb begin
    dup_live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((state_q[i] != EMPTY) && (id_q[i] == issue_id_i) &&
          !(pop && (PTR_W'(i) == rd_ptr_q))) begin
        dup_live = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= EMPTY;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
      if (push) begin
        id_q[wr_ptr_q]   <= issue_id_i;
        rd_q[wr_ptr_q]   <= issue_rd_i;
        data_q[wr_ptr_q] <= issue_data_i;
      end
    end
  end

  assign result_valid_o = head_committed;
  assign result_we_o    = head_committed;
  assign result_id_o    = head_committed ? id_q[rd_ptr_q]   : '0;
  assign result_rd_o    = head_committed ? rd_q[rd_ptr_q]   : '0;
  assign result_data_o  = head_committed ? data_q[rd_ptr_q] : '0;

  assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !dup_live);

`ifdef CVXIF_MAC4B_SCHED_PERF_EN
  logic [31:0] perf_issued_q, perf_killed_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_killed_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (push && (perf_issued_q != '1)) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (head_killed && (perf_killed_q != '1)) begin
        perf_killed_q <= perf_killed_q + 32'd1;
      end
      if (head_committed && !result_ready_i && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_killed_o = perf_killed_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_cvxif_mac4b_result_scheduler.sv
// tb/tb_cvxif_mac4b_result_scheduler.sv - scoreboard bench for cvxif_mac4b_result_scheduler
module tb_cvxif_mac4b_result_scheduler;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 3;
  localparam int DATA_W = 32;

  localparam int S_PEND = 1;
  localparam int S_COMM = 2;
  localparam int S_KILL = 3;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    int                st;
  } ent_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i = 1'b0;
  logic              issue_accept_i = 1'b0;
  logic              issue_ready_o;
  logic [ID_W-1:0]   issue_id_i = '0;
  logic [4:0]        issue_rd_i = '0;
  logic [DATA_W-1:0] issue_data_i = '0;
  logic              commit_valid_i = 1'b0;
  logic [ID_W-1:0]   commit_id_i = '0;
  logic              commit_kill_i = 1'b0;
  logic              result_valid_o;
  logic              result_ready_i = 1'b0;
  logic [ID_W-1:0]   result_id_o;
  logic [4:0]        result_rd_o;
  logic [DATA_W-1:0] result_data_o;
  logic              result_we_o;
`ifdef CVXIF_MAC4B_SCHED_PERF_EN
  logic [31:0]       perf_issued_o, perf_killed_o, perf_stall_o;
`endif

  cvxif_mac4b_result_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_accept_i (issue_accept_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .issue_data_i   (issue_data_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_data_o  (result_data_o),
    .result_we_o    (result_we_o)
`ifdef CVXIF_MAC4B_SCHED_PERF_EN
    ,
    .perf_issued_o  (perf_issued_o),
    .perf_killed_o  (perf_killed_o),
    .perf_stall_o   (perf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t mq[$];
  ent_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit in_mq(input logic [ID_W-1:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: an issue-ordered list of live instructions; the oldest leaves once resolved.
  task automatic model_step();
    bit   do_pop, do_push;
    ent_t e;
    do_pop  = 1'b0;
    do_push = issue_valid_i && issue_accept_i && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      if (mq[0].st == S_KILL) do_pop = 1'b1;
      else if (mq[0].st == S_COMM && result_ready_i) begin
        do_pop = 1'b1;
        exp_q.push_back(mq[0]);
      end
    end
    if (commit_valid_i) begin
      foreach (mq[i]) begin
        if (mq[i].st == S_PEND && mq[i].id == commit_id_i) mq[i].st = commit_kill_i ? S_KILL : S_COMM;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.id = issue_id_i; e.rd = issue_rd_i; e.data = issue_data_i; e.st = S_PEND;
      if (commit_valid_i && issue_id_i == commit_id_i) e.st = commit_kill_i ? S_KILL : S_COMM;
      mq.push_back(e);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (mq.size() > 0) && (mq[0].st == S_COMM);
    chk("issue_ready", 32'(issue_ready_o), 32'(mq.size() < DEPTH));
    chk("result_valid", 32'(result_valid_o), 32'(ev));
    chk("result_we", 32'(result_we_o), 32'(ev));
    if (ev) begin
      chk("head_id", 32'(result_id_o), 32'(mq[0].id));
      chk("head_rd", 32'(result_rd_o), 32'(mq[0].rd));
      chk("head_data", result_data_o, mq[0].data);
    end
  endtask

  task automatic cycle(input logic iv, input logic acc, input logic [ID_W-1:0] id,
                       input logic [4:0] rd, input logic [DATA_W-1:0] data,
                       input logic cv, input logic [ID_W-1:0] cid, input logic kl,
                       input logic rdy);
    issue_valid_i = iv; issue_accept_i = acc; issue_id_i = id; issue_rd_i = rd;
    issue_data_i = data; commit_valid_i = cv; commit_id_i = cid; commit_kill_i = kl;
    result_ready_i = rdy;
    model_step();
    @(posedge clk_i); #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, rdy);
  endtask

  // Monitor: every accepted result beat must match the oldest expected committed result.
  logic              stall_prev = 1'b0;
  logic [ID_W-1:0]   prev_id;
  logic [4:0]        prev_rd;
  logic [DATA_W-1:0] prev_data;
  int                n_beats = 0;

  always @(negedge clk_i) begin
    ent_t e;
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(result_valid_o), 32'd1);
        chk("hold_id", 32'(result_id_o), 32'(prev_id));
        chk("hold_data", result_data_o, prev_data);
        chk("hold_rd", 32'(result_rd_o), 32'(prev_rd));
      end
      stall_prev = result_valid_o && !result_ready_i;
      prev_id = result_id_o; prev_rd = result_rd_o; prev_data = result_data_o;
      if (result_valid_o && result_ready_i) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_id", 32'(result_id_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_id", 32'(result_id_o), 32'(e.id));
          chk("sb_rd", 32'(result_rd_o), 32'(e.rd));
          chk("sb_data", result_data_o, e.data);
        end
      end
    end
  end

  initial begin
    logic [ID_W-1:0] nid, cid;
    logic            iv, cv;
    logic [ID_W-1:0] pend[$];

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_result_valid", 32'(result_valid_o), 32'd0);
    chk("rst_result_data", result_data_o, 32'd0);
    chk("rst_result_id", 32'(result_id_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_outputs();

    // Same-cycle issue+commit: result one cycle later
    cycle(1, 1, 3'd1, 5'd5, 32'h10, 1, 3'd1, 0, 1);
    chk("lat_valid", 32'(result_valid_o), 32'd1);
    chk("lat_data", result_data_o, 32'h10);
    idle(1);
    chk("lat_empty", 32'(result_valid_o), 32'd0);

    // Fill, refuse fifth, then free one slot
    for (int i = 0; i < 4; i++) cycle(1, 1, 3'(i), 5'(i + 8), $urandom, 0, '0, 0, 1);
    chk("full_ready", 32'(issue_ready_o), 32'd0);
    cycle(1, 1, 3'd4, 5'd9, 32'hDEAD, 0, '0, 0, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd0, 0, 1);
    idle(1);
    chk("freed_ready", 32'(issue_ready_o), 32'd1);
    for (int i = 1; i < 4; i++) cycle(0, 0, '0, '0, '0, 1, 3'(i), 1, 1);
    idle(1);

    // Kill in the middle; unknown id and non-accepted issue change nothing
    for (int i = 0; i < 3; i++) cycle(1, 1, 3'(i), 5'(i + 1), $urandom, 0, '0, 0, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd1, 1, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd7, 0, 1);
    cycle(1, 0, 3'd6, 5'd3, 32'h55, 0, '0, 0, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd0, 0, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd2, 0, 1);
    repeat (3) idle(1);

    // Backpressure: head committed, ready low for three cycles
    cycle(1, 1, 3'd0, 5'd10, 32'hA5A5_0001, 0, '0, 0, 0);
    cycle(1, 1, 3'd1, 5'd11, 32'hA5A5_0002, 0, '0, 0, 0);
    cycle(0, 0, '0, '0, '0, 1, 3'd0, 0, 0);
    repeat (3) idle(0);
    cycle(0, 0, '0, '0, '0, 1, 3'd1, 0, 1);
    repeat (2) idle(1);

    // Reset with three live entries
    cycle(1, 1, 3'd0, 5'd1, 32'h111, 1, 3'd0, 0, 0);
    cycle(1, 1, 3'd1, 5'd2, 32'h222, 0, '0, 0, 0);
    cycle(1, 1, 3'd2, 5'd3, 32'h333, 0, '0, 0, 0);
    issue_valid_i = 0; commit_valid_i = 0; result_ready_i = 1;
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_valid", 32'(result_valid_o), 32'd0);
    chk("midrst_ready", 32'(issue_ready_o), 32'd1);
    mq.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cycle(0, 0, '0, '0, '0, 1, 3'd1, 0, 1);
    cycle(0, 0, '0, '0, '0, 1, 3'd2, 0, 1);
    repeat (2) idle(1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      do nid = 3'($urandom); while (in_mq(nid));
      iv = ($urandom_range(0, 99) < 60);
      pend.delete();
      foreach (mq[i]) if (mq[i].st == S_PEND) pend.push_back(mq[i].id);
      cv = ($urandom_range(0, 99) < 55);
      case ($urandom_range(0, 4))
        0, 1, 2: cid = (pend.size() > 0) ? pend[$urandom_range(0, pend.size() - 1)] : 3'($urandom);
        3:       cid = nid;
        default: cid = 3'($urandom);
      endcase
      cycle(iv, ($urandom_range(0, 9) != 0), nid, 5'($urandom), $urandom,
            cv, cid, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) < 70));
    end

    // Drain everything, bounded
    for (int n = 0; n < 60 && mq.size() > 0; n++) begin
      pend.delete();
      foreach (mq[i]) if (mq[i].st == S_PEND) pend.push_back(mq[i].id);
      if (pend.size() > 0) cycle(0, 0, '0, '0, '0, 1, pend[0], ($urandom_range(0, 3) == 0), 1);
      else idle(1);
    end
    idle(1);
    @(negedge clk_i); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("dut_idle_valid", 32'(result_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_mac4b_result_scheduler.md
Name: cvxif_mac4b_result_scheduler

Overview:
- Sits between the MAC4B coprocessor issue/decode path and the CV-X-IF result interface.
- Buffers each accepted MAC4B result (id, rd, sum) until the core commits or kills it.
- Returns committed results in issue order under x_result_ready backpressure.
- Replaces the current same-cycle, unbuffered result return, which ignores commit and result_ready.

Parameters:
DEPTH, 4, number of in-flight entries (power of two, >=2)
ID_W, 3, width of instruction id (matches X_ID_WIDTH)
DATA_W, 32, result data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  core presents an issue request
issue_accept_i  in  1  decoder accepts the request (opcode match)
issue_ready_o  out  1  scheduler can take a new entry
issue_id_i  in  ID_W  instruction id
issue_rd_i  in  5  destination register
issue_data_i  in  DATA_W  MAC4B sum for this request (combinational from datapath)
commit_valid_i  in  1  commit handshake
commit_id_i  in  ID_W  id being committed
commit_kill_i  in  1  1 = discard, 0 = commit
result_valid_o  out  1  head result available
result_ready_i  in  1  core takes result
result_id_o  out  ID_W  head id
result_rd_o  out  5  head rd
result_data_o  out  DATA_W  head data
result_we_o  out  1  write enable, equals result_valid_o

Behaviour:
- Circular buffer of DEPTH entries: wr_ptr, rd_ptr, count (log2(DEPTH)+1 bits), all wrapping modulo DEPTH.
- Per-entry state: EMPTY, PENDING, COMMITTED, KILLED.
- Reset (async): all entries EMPTY, pointers/count 0, issue_ready_o=1, result_valid_o=0, result outputs 0.
- issue_ready_o = (count < DEPTH), from registered count only.
- Push: issue_valid_i & issue_ready_o & issue_accept_i writes the entry at wr_ptr as PENDING and increments wr_ptr.
- Not accepted (issue_accept_i=0): no push.
- Commit with commit_valid_i: the single PENDING entry whose id == commit_id_i goes to COMMITTED (kill=0) or KILLED (kill=1).
- Same-cycle push with issue_id_i == commit_id_i: the new entry enters COMMITTED/KILLED directly.
- Commit matching no PENDING entry: ignored, no state change.
- Commit against a COMMITTED or KILLED entry: ignored.
- Head = entry at rd_ptr.
- result_valid_o = (head state == COMMITTED); result_* driven from the head registers.
- Pop when the head is COMMITTED and result_ready_i=1, or unconditionally in one cycle when the head is KILLED (no result beat). Pop sets the entry EMPTY and increments rd_ptr.
- Backpressure: while result_valid_o=1 and result_ready_i=0, all result_* hold stable.
- Latency: issue+commit in cycle t gives result_valid_o=1 in cycle t+1. Minimum one cycle; never combinational issue->result.
- Simultaneous push and pop: count unchanged. When full, push is refused even if a pop occurs that cycle.
- Throughput: one result per cycle when commits are timely and result_ready_i=1.
- Duplicate live ids are illegal; flagged by a simulation assertion, behaviour undefined.
- Reset mid-operation: all entries discarded, no result emitted after reset release.

Optional Feature:
- Macro: CVXIF_MAC4B_SCHED_PERF_EN.
- Defined: adds outputs perf_issued_o, perf_killed_o, perf_stall_o (32-bit, reset 0, saturating).
  - perf_issued_o: counts pushes.
  - perf_killed_o: counts KILLED pops.
  - perf_stall_o: counts cycles with result_valid_o=1 & result_ready_i=0.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Issue id=1 rd=5 data=0x0000_0010 with same-cycle commit kill=0, ready=1 -> next cycle result_valid_o=1, id=1, rd=5, data=0x10; empty after.
- Issue ids 0,1,2,3 with no commits -> issue_ready_o=0 after 4th push; 5th issue refused; commit id 0 with ready=1 -> id 0 returned, issue_ready_o=1 next cycle.
- Issue ids 0,1,2; commit 1 kill=1, then 0 and 2 kill=0 -> results id 0 then id 2 only; id 1 never appears on result.
- Commit id 0 before its result reaches head, result_ready_i=0 for 3 cycles -> result_valid_o held high, data stable 3 cycles, then one beat.
- Commit id=7 with no such entry -> no state change; issue_accept_i=0 -> no push.
- Reset asserted with 3 entries live -> result_valid_o=0 and issue_ready_o=1 immediately; no result after release.
